topk_stream_ctrl: RTL and testbench
===================================

// Module: topk_stream_ctrl
// PURPOSE
//  Sequences one top-K query through the selector/buffer feedback loop: clears the result
//  buffer, then feeds a stream of 2**LOG_INPUT_NUM-wide candidate chunks one at a time.
//  Only one chunk may be in flight, because the selector merges each chunk with the buffer
//  result. Signals completion when the last merge has landed. Sits between the stream
//  source and the top-K datapath.
// PARAMETERS
//  CNT_W        16   width of chunk count / chunk counter
//  TIMEOUT      64   max cycles to wait for sel_o_valid after issuing a chunk
//  TO_W         7    watchdog counter width; must satisfy 2**TO_W > TIMEOUT
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst          in   1      asynchronous, active-low reset
//  start        in   1      begin query; sampled only in IDLE
//  num_chunks   in   CNT_W  chunks in query; latched when start is accepted
//  in_valid     in   1      source has a chunk on the datapath x bus
//  in_ready     out  1      controller accepts chunk this cycle
//  sel_i_valid  out  1      to selector i_valid
//  sel_o_valid  in   1      from selector o_valid (merge result written to buffer)
//  buf_clr      out  1      one-cycle clear of result buffer to minimum sentinel
//  busy         out  1      high in every state except IDLE
//  done         out  1      one-cycle pulse: result bus y is final
//  timeout_err  out  1      sticky; set on watchdog expiry, cleared by next accepted start
//  chunk_cnt    out  CNT_W  chunks issued in current query
// BEHAVIOUR
//  Reset values:
//   - All outputs 0; state IDLE; latched count 0; watchdog 0.
//   - Reset mid-query drops any in-flight chunk; a later sel_o_valid in IDLE is ignored.
//  FSM IDLE -> CLEAR -> STREAM <-> WAIT -> DONE -> IDLE:
//   IDLE:
//    - start=1: latch num_chunks, clear chunk_cnt and timeout_err, go to CLEAR.
//    - start while busy is ignored.
//   CLEAR:
//    - buf_clr=1 for exactly this one cycle.
//    - Next state is STREAM if the latched count is >0, else DONE (zero-chunk query).
//   STREAM:
//    - in_ready=1.
//    - sel_i_valid = in_valid & in_ready. This is combinational, so the chunk is issued
//      in the same cycle it is accepted.
//    - On accept: chunk_cnt+1, watchdog cleared, go to WAIT.
//   WAIT:
//    - in_ready=0 and sel_i_valid=0. The watchdog increments each cycle.
//    - sel_o_valid=1: if chunk_cnt == latched count go to DONE, else go to STREAM.
//    - If the watchdog reaches TIMEOUT before sel_o_valid: set timeout_err, go to DONE.
//    - If sel_o_valid and watchdog==TIMEOUT occur in the same cycle, sel_o_valid wins.
//   DONE:
//    - done=1 for one cycle, then IDLE.
//    - y stays valid until the next buf_clr.
//  Other rules:
//   - sel_o_valid outside WAIT is ignored.
//   - in_valid outside STREAM is not accepted; the source must hold the chunk.
//   - Minimum cycles per chunk = 1 (accept) + selector latency.
//   - chunk_cnt never exceeds the latched count. There is no wrap: max count 2**CNT_W-1.
//  Query latency, from start to done:
//   - 1 (IDLE) + 1 (CLEAR) + sum over chunks of (accept wait + 1 + selector latency) + 1.
// TESTING
//  T1 start, num_chunks=3, in_valid held 1, selector latency 2
//     -> buf_clr once; 3 sel_i_valid pulses spaced 3 cycles apart; done once; chunk_cnt=3.
//  T2 num_chunks=0 -> buf_clr, then done on the next cycle; no sel_i_valid; chunk_cnt=0.
//  T3 in_valid low for 5 cycles mid-query
//     -> in_ready stays 1; no issue until in_valid returns; chunk_cnt correct at done.
//  T4 sel_o_valid withheld after chunk 2 of 4, TIMEOUT=64
//     -> timeout_err=1 and done exactly 64 cycles later; next start clears timeout_err.
//  T5 rst low while in WAIT; spurious sel_o_valid after release
//     -> all outputs 0, stays IDLE, no done.
//  T6 start pulsed during STREAM and during DONE -> ignored; latched count unchanged.

Source files
------------

// File: rtl/topk_stream_ctrl_if.sv
// topk_stream_ctrl_if: handshake bundle between stream source, query controller and top-K datapath
interface topk_stream_ctrl_if #(parameter int CNT_W = 16);
  logic             start;
  logic [CNT_W-1:0] num_chunks;
  logic             in_valid;
  logic             in_ready;
  logic             sel_i_valid;
  logic             sel_o_valid;
  logic             buf_clr;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [CNT_W-1:0] chunk_cnt;
  modport slave (
    input  start, num_chunks, in_valid, sel_o_valid,
    output in_ready, sel_i_valid, buf_clr, busy, done, timeout_err, chunk_cnt
  );
  modport master (
    output start, num_chunks, in_valid, sel_o_valid,
    input  in_ready, sel_i_valid, buf_clr, busy, done, timeout_err, chunk_cnt
  );
endinterface

// File: rtl/topk_stream_ctrl.sv
// topk_stream_ctrl: sequences one top-K query, one chunk in flight through the selector/buffer loop
module topk_stream_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input logic                clk,
  input logic                rst_n,
  topk_stream_ctrl_if.slave  bus
);
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, STREAM = 3'd2, WAIT = 3'd3, DONE = 3'd4;
  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] total;
  logic [TO_W-1:0]  wd;
  logic             accept, expire;
  assign bus.in_ready    = state == STREAM;
  assign accept          = bus.in_ready & bus.in_valid;
  assign bus.sel_i_valid = accept;
  assign bus.buf_clr     = state == CLEAR;
  assign bus.busy        = state != IDLE;
  assign bus.done        = state == DONE;
  // watchdog reaches TIMEOUT on the edge that ends this WAIT cycle
  assign expire          = wd == TO_W'(TIMEOUT - 1);
  // next state; a merge result arriving on the expiry cycle still counts as a normal finish
  always_comb
    case (state)
      IDLE:    state_nxt = bus.start ? CLEAR : IDLE;
      CLEAR:   state_nxt = total != '0 ? STREAM : DONE;
      STREAM:  state_nxt = accept ? WAIT : STREAM;
      WAIT:    state_nxt = bus.sel_o_valid ? (bus.chunk_cnt == total ? DONE : STREAM) : (expire ? DONE : WAIT);
      default: state_nxt = IDLE;
    endcase
  // state, latched count, chunk counter, watchdog and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state           <= IDLE;
      total           <= '0;
      wd              <= '0;
      bus.chunk_cnt   <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start) begin
        total           <= bus.num_chunks;
        bus.chunk_cnt   <= '0;
        bus.timeout_err <= 1'b0;
      end
      if (accept) begin
        bus.chunk_cnt <= bus.chunk_cnt + 1'b1;
        wd            <= '0;
      end
      if (state == WAIT) begin
        wd <= wd + 1'b1;
        if (!bus.sel_o_valid && expire) bus.timeout_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_topk_stream_ctrl.sv
// tb_topk_stream_ctrl: table-driven queries with a done-time scoreboard plus reset/ignore corner cases
module tb_topk_stream_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  topk_stream_ctrl_if #(.CNT_W(16)) bus();
  topk_stream_ctrl #(.CNT_W(16), .TIMEOUT(64), .TO_W(7)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    int n, lat, gap_at, gap_len, hold_at, poke;
    int exp_cnt, exp_to, exp_done;
  } vec_t;
  typedef struct { int cnt, to, done_cyc, gaps; } exp_t;
  exp_t sbq[$];
  vec_t tbl[9];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, 32'(bus.busy), 0);
    check({tag, " done"}, 32'(bus.done), 0);
    check({tag, " in_ready"}, 32'(bus.in_ready), 0);
    check({tag, " sel_i_valid"}, 32'(bus.sel_i_valid), 0);
    check({tag, " buf_clr"}, 32'(bus.buf_clr), 0);
  endtask
  task automatic run_query(input vec_t v, input int idx);
    int cyc = 0, issued = 0, cd = 0, gap = 0, clr = 0, pulses = 0;
    bit seen = 0;
    exp_t e;
    string tag = $sformatf("v%0d", idx);
    sbq.push_back('{v.exp_cnt, v.exp_to, v.exp_done, (v.gap_at >= 0 && v.gap_at < v.n) ? v.gap_len : 0});
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_chunks = 16'(v.n);
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      cyc++;
      bus.start = v.poke != 0 && cyc == 2;
      bus.num_chunks = v.poke != 0 ? 16'd9 : 16'(v.n);
      bus.sel_o_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && issued != v.hold_at) bus.sel_o_valid = 1'b1;
      end
      bus.in_valid = !(issued == v.gap_at && gap < v.gap_len);
      #1;
      if (cyc == 1) check({tag, " timeout_err cleared"}, 32'(bus.timeout_err), 0);
      if (bus.in_ready && !bus.in_valid) gap++;
      if (bus.buf_clr) begin
        clr++;
        check({tag, " buf_clr cycle"}, cyc, 1);
      end
      if (bus.sel_i_valid) begin
        issued++;
        pulses++;
        cd = v.lat;
      end
      if (bus.done) begin
        seen = 1;
        bus.start = v.poke != 0;
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s scoreboard: done with no expected entry", tag);
        end else begin
          e = sbq.pop_front();
          check({tag, " done cycle"}, cyc, e.done_cyc);
          check({tag, " chunk_cnt"}, 32'(bus.chunk_cnt), e.cnt);
          check({tag, " timeout_err"}, 32'(bus.timeout_err), e.to);
          check({tag, " sel_i_valid pulses"}, pulses, e.cnt);
          check({tag, " buf_clr pulses"}, clr, 1);
          check({tag, " in_ready while in_valid low"}, gap, e.gaps);
        end
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s done: not seen within 400 cycles, expected at cycle %0d", tag, v.exp_done);
      void'(sbq.pop_front());
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.sel_o_valid = 1'b0;
    #1;
    check_idle_outputs({tag, " after done"});
    check({tag, " chunk_cnt held"}, 32'(bus.chunk_cnt), v.exp_cnt);
    check({tag, " timeout_err held"}, 32'(bus.timeout_err), v.exp_to);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.num_chunks = '0;
    bus.in_valid = 1'b0;
    bus.sel_o_valid = 1'b0;
    //         n  lat gap_at gap_len hold poke | cnt to done
    tbl[0] = '{3, 2,  -1,    0,      -1,  0,     3,  0, 11};
    tbl[1] = '{0, 2,  -1,    0,      -1,  0,     0,  0, 2};
    tbl[2] = '{3, 2,  1,     5,      -1,  0,     3,  0, 16};
    tbl[3] = '{4, 2,  -1,    0,      2,   0,     2,  1, 70};
    tbl[4] = '{2, 1,  0,     3,      -1,  0,     2,  0, 9};
    tbl[5] = '{1, 64, -1,    0,      -1,  0,     1,  0, 67};
    tbl[6] = '{1, 3,  -1,    0,      1,   0,     1,  1, 67};
    tbl[7] = '{2, 2,  -1,    0,      -1,  1,     2,  0, 8};
    tbl[8] = '{5, 1,  -1,    0,      -1,  0,     5,  0, 12};
    #3;
    check_idle_outputs("reset");
    check("reset chunk_cnt", 32'(bus.chunk_cnt), 0);
    check("reset timeout_err", 32'(bus.timeout_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) run_query(tbl[i], i);
    check("scoreboard drained", sbq.size(), 0);
    // reset while a chunk is in flight, then a stray merge result
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_chunks = 16'd3;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t5 in WAIT busy", 32'(bus.busy), 1);
    check("t5 in WAIT in_ready", 32'(bus.in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t5 in reset");
    check("t5 in reset chunk_cnt", 32'(bus.chunk_cnt), 0);
    check("t5 in reset timeout_err", 32'(bus.timeout_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.sel_o_valid = 1'b1;
    @(negedge clk);
    bus.sel_o_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_idle_outputs($sformatf("t5 after release %0d", k));
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
